// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; registered read data.
// Overflowing writes and underflowing reads are dropped without touching state.
module sync_fifo #(
  parameter int DATA_WIDTH = 4,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  input  logic                  wr_en,
  input  logic                  rd_en,
  output logic                  empty,
  output logic                  full
);

  localparam logic [ADDR_WIDTH:0] PTR_ONE = 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH:0]   wr_ptr;
  logic [ADDR_WIDTH:0]   rd_ptr;
  logic                  wr_accept;
  logic                  rd_accept;

  // Flags come only from registered pointers, so inputs never reach an output.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]) &&
                 (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]);

  assign wr_accept = wr_en && !full;
  assign rd_accept = rd_en && !empty;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      data_out <= '0;
    end else begin
      if (wr_accept) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (rd_accept) begin
        data_out <= mem[rd_ptr[ADDR_WIDTH-1:0]];
        rd_ptr   <= rd_ptr + PTR_ONE;
      end
    end
  end

  // NOTE: storage has no reset; the pointers alone define which words are valid,
  // which lets the array map onto plain RAM.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[wr_ptr[ADDR_WIDTH-1:0]] <= data_in;
    end
  end

endmodule

// File: tb/tb_sync_fifo.sv
// Directed plus randomized stimulus for sync_fifo, checked against a queue model.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_sync_fifo;

  localparam int DW    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] data_in;
  logic [DW-1:0] data_out;
  logic          wr_en;
  logic          rd_en;
  logic          empty;
  logic          full;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] model_q [$];
  logic [DW-1:0] model_dout;

  sync_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .data_in  (data_in),
    .data_out (data_out),
    .wr_en    (wr_en),
    .rd_en    (rd_en),
    .empty    (empty),
    .full     (full)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_empty"}, 32'(empty), 32'(model_q.size() == 0));
    check({tag, "_full"},  32'(full),  32'(model_q.size() == DEPTH));
    check({tag, "_dout"},  32'(data_out), 32'(model_dout));
  endtask

  // One clock: drive at the falling edge, update model at the rising edge,
  // compare at the next falling edge.
  task automatic step(input string tag, input logic wr, input logic rd, input logic [DW-1:0] din);
    bit wr_ok;
    bit rd_ok;
    wr_en   = wr;
    rd_en   = rd;
    data_in = din;
    wr_ok = wr && (model_q.size() < DEPTH);
    rd_ok = rd && (model_q.size() > 0);
    @(posedge clk);
    if (rd_ok) model_dout = model_q.pop_front();
    if (wr_ok) model_q.push_back(din);
    @(negedge clk);
    check_outputs(tag);
  endtask

  task automatic async_reset(input string tag);
    #2;
    rst = 1'b1;
    #1;
    model_q.delete();
    model_dout = '0;
    check_outputs(tag);
    @(negedge clk);
    rst   = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  initial begin
    rst        = 1'b0;
    wr_en      = 1'b0;
    rd_en      = 1'b0;
    data_in    = '0;
    model_dout = '0;

    // Reset without any clock edge in between.
    @(negedge clk);
    async_reset("reset");

    // Fill with 0..15, then one overflowing write.
    for (int i = 0; i < DEPTH; i++) step("fill", 1'b1, 1'b0, DW'(i));
    step("overflow", 1'b1, 1'b0, 4'h0);

    // Drain past empty; data_out must hold 15 afterwards.
    for (int i = 0; i < 20; i++) step("drain", 1'b0, 1'b1, 4'h0);
    check("drain_hold", 32'(data_out), 32'hF);

    // Wrap-around: pointers end up past index 15.
    for (int i = 0; i < 10; i++) step("wrap_w10", 1'b1, 1'b0, DW'($urandom));
    for (int i = 0; i < 10; i++) step("wrap_r10", 1'b0, 1'b1, 4'h0);
    for (int i = 0; i < DEPTH; i++) step("wrap_fill", 1'b1, 1'b0, (i % 2 == 0) ? 4'hA : 4'h5);
    for (int i = 0; i < DEPTH; i++) step("wrap_read", 1'b0, 1'b1, 4'h0);

    // Simultaneous read/write at occupancy 8.
    for (int i = 0; i < 8; i++) step("sim_pre", 1'b1, 1'b0, DW'($urandom));
    for (int i = 0; i < 5; i++) step("sim_both", 1'b1, 1'b1, DW'($urandom));
    check("sim_occupancy", 32'(model_q.size()), 32'd8);
    for (int i = 0; i < 8; i++) step("sim_drain", 1'b0, 1'b1, 4'h0);

    // Simultaneous at the full boundary: read accepted, write dropped.
    for (int i = 0; i < DEPTH; i++) step("fb_fill", 1'b1, 1'b0, DW'($urandom));
    step("fb_both", 1'b1, 1'b1, 4'h3);
    for (int i = 0; i < DEPTH; i++) step("fb_drain", 1'b0, 1'b1, 4'h0);

    // Simultaneous at empty: only the write lands, no bypass.
    step("empty_both", 1'b1, 1'b1, 4'h9);
    step("empty_both_rd", 1'b0, 1'b1, 4'h0);

    // Randomized traffic with shifting write/read bias.
    for (int i = 0; i < 400; i++) begin
      int wbias;
      wbias = (i / 100) % 2 == 0 ? 70 : 30;
      step("random", $urandom_range(99) < wbias, $urandom_range(99) < (100 - wbias),
           DW'($urandom));
    end

    // Reset in the middle of a burst discards contents.
    for (int i = 0; i < 6; i++) step("burst", 1'b1, 1'b0, DW'($urandom));
    wr_en = 1'b1;
    async_reset("mid_reset");
    for (int i = 0; i < 4; i++) step("post_reset_w", 1'b1, 1'b0, DW'($urandom));
    for (int i = 0; i < 6; i++) step("post_reset_r", 1'b0, 1'b1, 4'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
